mem_access_unit: RTL and testbench

- MEM-stage data-memory access unit; sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Executes loads and stores over a req/ack data bus, handling byte-lane alignment (big-endian).
- Implements LL/SC: reads the committed LLbit plus the WB-stage forwarded LLbit, and produces the llbit write (we/value) that the MEM/WB register carries to the LLbit register.
- Stalls the pipeline while a bus access is outstanding.

---
 rtl/mem_access_unit.sv | 245 ++++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: big-endian loads/stores over a req/ack bus, LL/SC, pipeline stall.
// Optional bus timeout (adds bus_err_o) is enabled by defining MEM_BUS_TIMEOUT_EN.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [3:0]  mem_op_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] store_data_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic        llbit_i,
    input  logic        wb_llbit_we_i,
    input  logic        wb_llbit_value_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        llbit_we_o,
    output logic        llbit_value_o,
    output logic        adel_o,
    output logic        ades_o,
    output logic        stallreq_o
`ifdef MEM_BUS_TIMEOUT_EN
    ,
    output logic        bus_err_o
`endif
);

    typedef enum logic [3:0] {
        OP_NONE = 4'd0, OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4,
        OP_LW   = 4'd5, OP_SB = 4'd6, OP_SH  = 4'd7, OP_SW = 4'd8, OP_LL  = 4'd9,
        OP_SC   = 4'd10
    } mem_op_e;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_HOLD, S_ABORT} state_e;

    mem_op_e     op;
    state_e      state;
    logic        is_load, is_store, is_half, is_word, is_mem;
    logic        misaligned, eff_llbit, sc_fail, start;
    logic [3:0]  sel;
    logic [31:0] st_data;
    logic [31:0] rdata_q;
    logic [31:0] load_data;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic        timed_out;

    assign op = mem_op_e'(mem_op_i);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        is_half  = 1'b0;
        is_word  = 1'b0;
        case (op)
            OP_LB, OP_LBU: is_load = 1'b1;
            OP_LH, OP_LHU: begin is_load = 1'b1; is_half = 1'b1; end
            OP_LW, OP_LL:  begin is_load = 1'b1; is_word = 1'b1; end
            OP_SB:         is_store = 1'b1;
            OP_SH:         begin is_store = 1'b1; is_half = 1'b1; end
            OP_SW, OP_SC:  begin is_store = 1'b1; is_word = 1'b1; end
            default: ;
        endcase
    end

    assign is_mem     = is_load | is_store;
    assign misaligned = (is_half & mem_addr_i[0]) | (is_word & (mem_addr_i[1:0] != 2'b00));
    assign eff_llbit  = wb_llbit_we_i ? wb_llbit_value_i : llbit_i;
    assign sc_fail    = (op == OP_SC) & ~eff_llbit & ~misaligned;
    assign start      = is_mem & ~misaligned & ~sc_fail & ~flush;
    assign adel_o     = is_load & misaligned;
    assign ades_o     = is_store & misaligned;

    // Big-endian lanes: the lowest address maps to bits [31:24] / sel bit 3.
    always_comb begin
        if (is_word) begin
            sel     = 4'b1111;
            st_data = store_data_i;
        end else if (is_half) begin
            sel     = mem_addr_i[1] ? 4'b0011 : 4'b1100;
            st_data = {2{store_data_i[15:0]}};
        end else begin
            sel     = 4'b1000 >> mem_addr_i[1:0];
            st_data = {4{store_data_i[7:0]}};
        end
    end

    always_comb begin
        case (mem_addr_i[1:0])
            2'b00:   rd_byte = rdata_q[31:24];
            2'b01:   rd_byte = rdata_q[23:16];
            2'b10:   rd_byte = rdata_q[15:8];
            default: rd_byte = rdata_q[7:0];
        endcase
        rd_half = mem_addr_i[1] ? rdata_q[15:0] : rdata_q[31:16];
        case (op)
            OP_LB:   load_data = {{24{rd_byte[7]}}, rd_byte};
            OP_LBU:  load_data = {24'd0, rd_byte};
            OP_LH:   load_data = {{16{rd_half[15]}}, rd_half};
            OP_LHU:  load_data = {16'd0, rd_half};
            default: load_data = rdata_q;
        endcase
    end

`ifdef MEM_BUS_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] to_cnt;
    logic       timed_out_q;
    logic       to_hit;

    assign timed_out = timed_out_q;
    assign to_hit    = ~bus_ack_i & (to_cnt == TO_LAST);
`else
    logic unused_timeout;

    assign timed_out      = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            rdata_q     <= '0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_sel_o   <= '0;
            bus_wdata_o <= '0;
`ifdef MEM_BUS_TIMEOUT_EN
            to_cnt      <= '0;
            timed_out_q <= 1'b0;
            bus_err_o   <= 1'b0;
`endif
        end else begin
`ifdef MEM_BUS_TIMEOUT_EN
            bus_err_o <= 1'b0;
            if (state == S_ACCESS || state == S_ABORT) to_cnt <= to_cnt + 8'd1;
`endif
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_ACCESS;
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= is_store;
                        bus_addr_o  <= {mem_addr_i[31:2], 2'b00};
                        bus_sel_o   <= sel;
                        bus_wdata_o <= is_store ? st_data : 32'd0;
`ifdef MEM_BUS_TIMEOUT_EN
                        to_cnt      <= '0;
                        timed_out_q <= 1'b0;
`endif
                    end
                end
                S_ACCESS: begin
                    if (bus_ack_i) begin
                        rdata_q   <= bus_rdata_i;
                        bus_req_o <= 1'b0;
                        state     <= flush ? S_IDLE : S_HOLD;
`ifdef MEM_BUS_TIMEOUT_EN
                    end else if (to_hit) begin
                        bus_req_o   <= 1'b0;
                        bus_err_o   <= 1'b1;
                        timed_out_q <= 1'b1;
                        state       <= S_HOLD;
`endif
                    end else if (flush) begin
                        state <= S_ABORT;
                    end
                end
                S_HOLD: state <= S_IDLE;
                S_ABORT: begin
`ifdef MEM_BUS_TIMEOUT_EN
                    if (bus_ack_i || to_hit) begin
                        bus_err_o <= ~bus_ack_i;
`else
                    if (bus_ack_i) begin
`endif
                        bus_req_o <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        case (state)
            S_IDLE:  stallreq_o = start;
            S_HOLD:  stallreq_o = 1'b0;
            default: stallreq_o = 1'b1;
        endcase
    end

    always_comb begin
        wd_o          = wd_i;
        wreg_o        = wreg_i;
        wdata_o       = wdata_i;
        llbit_we_o    = 1'b0;
        llbit_value_o = 1'b0;
        if (state == S_HOLD) begin
            if (timed_out) begin
                wreg_o = 1'b0;
            end else begin
                case (op)
                    OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: wdata_o = load_data;
                    OP_LL: begin
                        wdata_o       = load_data;
                        llbit_we_o    = 1'b1;
                        llbit_value_o = 1'b1;
                    end
                    OP_SC: begin
                        wdata_o    = 32'd1;
                        llbit_we_o = 1'b1;
                    end
                    default: ;
                endcase
            end
        end else if (state != S_IDLE) begin
            wreg_o = 1'b0;
        end else if (is_mem) begin
            // A failed SC retires at once with 0; anything else here is misaligned or just starting.
            if (sc_fail) wdata_o = 32'd0;
            else         wreg_o  = 1'b0;
        end
        if (flush) begin
            wreg_o     = 1'b0;
            llbit_we_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed instructions, bus responder and retire monitor.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [3:0]  mem_op_i;
    logic [31:0] mem_addr_i, store_data_i, wdata_i;
    logic [4:0]  wd_i;
    logic        wreg_i, llbit_i, wb_llbit_we_i, wb_llbit_value_i;
    logic        bus_req_o, bus_we_o, bus_ack_i;
    logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
    logic [3:0]  bus_sel_o;
    logic [4:0]  wd_o;
    logic        wreg_o, llbit_we_o, llbit_value_o, adel_o, ades_o, stallreq_o;
    logic [31:0] wdata_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        llwe, llval, adel, ades;
    } wb_exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
    } bus_exp_t;

    wb_exp_t  wb_q[$];
    bus_exp_t bus_q[$];

    mem_access_unit dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i), .store_data_i(store_data_i),
        .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .llbit_i(llbit_i), .wb_llbit_we_i(wb_llbit_we_i), .wb_llbit_value_i(wb_llbit_value_i),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o),
        .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
        .llbit_we_o(llbit_we_o), .llbit_value_o(llbit_value_o),
        .adel_o(adel_o), .ades_o(ades_o), .stallreq_o(stallreq_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_wb(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                           input logic llwe, input logic llval, input logic adel, input logic ades);
        wb_exp_t e;
        e.wd = wd; e.wreg = wreg; e.wdata = wdata;
        e.llwe = llwe; e.llval = llval; e.adel = adel; e.ades = ades;
        wb_q.push_back(e);
    endtask

    task automatic push_bus(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                            input logic [31:0] wdata, input logic [31:0] rdata, input int delay);
        bus_exp_t b;
        b.we = we; b.addr = addr; b.sel = sel; b.wdata = wdata; b.rdata = rdata; b.delay = delay;
        bus_q.push_back(b);
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                         input logic llbit, input logic wbwe, input logic wbval);
        mem_op_i = op; mem_addr_i = addr; store_data_i = sdata;
        wd_i = wd; wreg_i = wreg; wdata_i = wdata;
        llbit_i = llbit; wb_llbit_we_i = wbwe; wb_llbit_value_i = wbval;
    endtask

    // Waits (bounded) for the cycle where stallreq_o is low, counting stalled cycles.
    task automatic wait_retire(input string name, input int exp_stall);
        int  stalls = 0;
        bit  done   = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!stallreq_o) begin
                done = 1;
                break;
            end
            stalls++;
        end
        if (!done) check({name, "_retire_timeout"}, 32'd0, 32'd1);
        check({name, "_stall_cycles"}, stalls, exp_stall);
    endtask

    task automatic run_instr(input string name, input logic [3:0] op, input logic [31:0] addr,
                             input logic [31:0] sdata, input logic [4:0] wd, input logic wreg,
                             input logic [31:0] wdata, input logic llbit, input logic wbwe,
                             input logic wbval, input int exp_stall);
        drive(op, addr, sdata, wd, wreg, wdata, llbit, wbwe, wbval);
        wait_retire(name, exp_stall);
        @(posedge clk); #1;
        drive(4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Retire monitor: compares writeback outputs whenever the pipeline advances.
    always @(negedge clk) begin
        if (rst_n && !stallreq_o && wb_q.size() > 0) begin
            wb_exp_t e;
            e = wb_q.pop_front();
            check("wd_o", wd_o, e.wd);
            check("wreg_o", wreg_o, e.wreg);
            check("wdata_o", wdata_o, e.wdata);
            check("llbit_we_o", llbit_we_o, e.llwe);
            check("llbit_value_o", llbit_value_o, e.llval);
            check("adel_o", adel_o, e.adel);
            check("ades_o", ades_o, e.ades);
        end
    end

    // Bus responder: checks each request against the expected transaction, then acks after delay cycles.
    initial begin
        bus_ack_i   = 1'b0;
        bus_rdata_i = 32'd0;
        forever begin
            @(negedge clk);
            if (rst_n && bus_req_o) begin
                if (bus_q.size() == 0) begin
                    check("bus_req_spurious", bus_req_o, 1'b0);
                end else begin
                    bus_exp_t b;
                    b = bus_q.pop_front();
                    check("bus_we_o", bus_we_o, b.we);
                    check("bus_addr_o", bus_addr_o, b.addr);
                    check("bus_sel_o", bus_sel_o, b.sel);
                    check("bus_wdata_o", bus_wdata_o, b.wdata);
                    repeat (b.delay - 1) @(negedge clk);
                    bus_ack_i   = 1'b1;
                    bus_rdata_i = b.rdata;
                    @(negedge clk);
                    bus_ack_i   = 1'b0;
                    bus_rdata_i = 32'd0;
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        drive(4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        #12;
        check("rst_bus_req", bus_req_o, 1'b0);
        check("rst_bus_we", bus_we_o, 1'b0);
        check("rst_bus_addr", bus_addr_o, 32'd0);
        check("rst_bus_sel", bus_sel_o, 4'd0);
        check("rst_bus_wdata", bus_wdata_o, 32'd0);
        check("rst_stallreq", stallreq_o, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Non-memory op passes straight through.
        push_wb(5'd3, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr("none", 4'd0, 32'h0, 32'h0, 5'd3, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 0);

        // LB 0x103, ack on second ACCESS cycle: lane 3, sign-extended.
        push_bus(1'b0, 32'h100, 4'b0001, 32'h0, 32'h000000F0, 2);
        push_wb(5'd4, 1'b1, 32'hFFFFFFF0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr("lb", 4'd1, 32'h103, 32'h0, 5'd4, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 3);

        push_bus(1'b0, 32'h100, 4'b0100, 32'h0, 32'h12AB5678, 1);
        push_wb(5'd5, 1'b1, 32'h000000AB, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr("lbu", 4'd2, 32'h101, 32'h0, 5'd5, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 2);

        push_bus(1'b0, 32'h100, 4'b0011, 32'h0, 32'h12348001, 1);
        push_wb(5'd6, 1'b1, 32'hFFFF8001, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr("lh", 4'd3, 32'h102, 32'h0, 5'd6, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 2);

        push_bus(1'b0, 32'h100, 4'b1100, 32'h0, 32'h80011234, 1);
        push_wb(5'd7, 1'b1, 32'h00008001, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr("lhu", 4'd4, 32'h100, 32'h0, 5'd7, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 2);

        push_bus(1'b0, 32'h104, 4'b1111, 32'h0, 32'hCAFEBABE, 3);
        push_wb(5'd8, 1'b1, 32'hCAFEBABE, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr("lw", 4'd5, 32'h104, 32'h0, 5'd8, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 4);

        // LL then SC; SC sees llbit only through the WB forward.
        push_bus(1'b0, 32'h200, 4'b1111, 32'h0, 32'h11223344, 1);
        push_wb(5'd9, 1'b1, 32'h11223344, 1'b1, 1'b1, 1'b0, 1'b0);
        run_instr("ll", 4'd9, 32'h200, 32'h0, 5'd9, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 2);

        push_bus(1'b1, 32'h200, 4'b1111, 32'h000000AB, 32'h0, 1);
        push_wb(5'd10, 1'b1, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b0);
        run_instr("sc_ok", 4'd10, 32'h200, 32'h000000AB, 5'd10, 1'b1, 32'h0, 1'b0, 1'b1, 1'b1, 2);

        push_wb(5'd11, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr("sc_fail", 4'd10, 32'h200, 32'h000000AB, 5'd11, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 0);

        // Misaligned accesses: exception flag, no bus, no writeback.
        push_wb(5'd12, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_instr("lw_mis", 4'd5, 32'h102, 32'h0, 5'd12, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 0);

        push_wb(5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_instr("sh_mis", 4'd7, 32'h101, 32'h1234, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 0);

        push_bus(1'b1, 32'h108, 4'b0011, 32'h12341234, 32'h0, 1);
        push_wb(5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr("sh", 4'd7, 32'h10A, 32'h00001234, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2);

        push_bus(1'b1, 32'h104, 4'b0001, 32'h5A5A5A5A, 32'h0, 2);
        push_wb(5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr("sb", 4'd6, 32'h107, 32'h0000005A, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3);

        // Flush during ACCESS: request stays up until the late ack, nothing is written back.
        push_bus(1'b0, 32'h300, 4'b1111, 32'h0, 32'h55555555, 5);
        drive(4'd5, 32'h300, 32'h0, 5'd13, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("flush_req_in_access", bus_req_o, 1'b1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        drive(4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        push_wb(5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_bus_req_held", bus_req_o, 1'b1);
            check("abort_stallreq", stallreq_o, 1'b1);
            check("abort_wreg_o", wreg_o, 1'b0);
        end
        wait_retire("abort", 1);
        check("abort_bus_req_dropped", bus_req_o, 1'b0);
        @(posedge clk); #1;

        check("wb_queue_drained", wb_q.size(), 32'd0);
        check("bus_queue_drained", bus_q.size(), 32'd0);

        // Reset in the middle of ACCESS drops the request immediately.
        push_bus(1'b0, 32'h400, 4'b1111, 32'h0, 32'h0, 8);
        drive(4'd5, 32'h400, 32'h0, 5'd1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("pre_reset_bus_req", bus_req_o, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_access_reset_bus_req", bus_req_o, 1'b0);
        drive(4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        check("mid_access_reset_stallreq", stallreq_o, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
